// File: rtl/mchan_pkg.sv
// Shared definitions for the transaction-queue consumers: queued-word field
// offsets for the default widths, opcode encoding and the issuer FSM states.
package mchan_pkg;

  localparam int DEF_EXT_ADD_WIDTH  = 32;
  localparam int DEF_TCDM_ADD_WIDTH = 32;
  localparam int DEF_LEN_WIDTH      = 16;
  localparam int DEF_SID_WIDTH      = 4;

  localparam int EXT_LSB  = 0;
  localparam int TCDM_LSB = EXT_LSB + DEF_EXT_ADD_WIDTH;
  localparam int LEN_LSB  = TCDM_LSB + DEF_TCDM_ADD_WIDTH;
  localparam int OPC_BIT  = LEN_LSB + DEF_LEN_WIDTH;
  localparam int SID_LSB  = OPC_BIT + 1;

  typedef enum logic {
    OPC_TX = 1'b0,
    OPC_RX = 1'b1
  } opc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issuer_state_t;

endpackage

// File: rtl/trans_burst_calc.sv
// Burst sizing: bytes = min(remaining, max burst, room left in the current page);
// last is set when this burst drains the remaining count.
module trans_burst_calc #(
  parameter int REM_WIDTH       = 17,
  parameter int MAX_BURST_BYTES = 256,
  parameter int PAGE_LOG2       = 12,
  parameter int BYTES_WIDTH     = $clog2(MAX_BURST_BYTES) + 1
) (
  input  logic [PAGE_LOG2-1:0]   page_off_i,
  input  logic [REM_WIDTH-1:0]   rem_i,
  output logic [BYTES_WIDTH-1:0] bytes_o,
  output logic                   last_o
);

  localparam int CW = (REM_WIDTH > PAGE_LOG2 + 1) ? REM_WIDTH : PAGE_LOG2 + 1;

  logic [CW-1:0] room;
  logic [CW-1:0] rem_ext;
  logic [CW-1:0] max_ext;
  logic [CW-1:0] sel;

  always_comb begin
    // A zero page offset yields a full page of room, so the max burst governs.
    room    = CW'({1'b1, {PAGE_LOG2{1'b0}}}) - CW'(page_off_i);
    rem_ext = CW'(rem_i);
    max_ext = CW'(MAX_BURST_BYTES);
    sel     = rem_ext;
    if (max_ext < sel) sel = max_ext;
    if (room < sel)    sel = room;
    bytes_o = sel[BYTES_WIDTH-1:0];
    last_o  = (sel == rem_ext);
  end

endmodule

// File: rtl/trans_burst_issuer.sv
// Pops queued transactions and splits them into page-safe bursts.
// Define TRANS_BURST_ISSUER_BACK2BACK_EN to accept the next transaction on the last burst handshake.
module trans_burst_issuer
  import mchan_pkg::*;
#(
  parameter int TCDM_ADD_WIDTH  = DEF_TCDM_ADD_WIDTH,
  parameter int EXT_ADD_WIDTH   = DEF_EXT_ADD_WIDTH,
  parameter int MCHAN_LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int SID_WIDTH       = DEF_SID_WIDTH,
  parameter int TRANS_WIDTH     = EXT_ADD_WIDTH + TCDM_ADD_WIDTH + MCHAN_LEN_WIDTH + 1 + SID_WIDTH,
  parameter int MAX_BURST_BYTES = 256,
  parameter int PAGE_LOG2       = 12,
  parameter int BURST_LEN_WIDTH = $clog2(MAX_BURST_BYTES)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  output logic                       gnt_o,
  input  logic [TRANS_WIDTH-1:0]     dat_i,
  output logic                       burst_valid_o,
  input  logic                       burst_ready_i,
  output logic [EXT_ADD_WIDTH-1:0]   burst_ext_add_o,
  output logic [TCDM_ADD_WIDTH-1:0]  burst_tcdm_add_o,
  output logic [BURST_LEN_WIDTH-1:0] burst_len_o,
  output logic                       burst_opc_o,
  output logic [SID_WIDTH-1:0]       burst_sid_o,
  output logic                       burst_last_o,
  output logic                       busy_o
);

  localparam int REM_W   = MCHAN_LEN_WIDTH + 1;
  localparam int BYTES_W = BURST_LEN_WIDTH + 1;

  issuer_state_t             state_q, state_d;
  logic [EXT_ADD_WIDTH-1:0]  ext_q, ext_d;
  logic [TCDM_ADD_WIDTH-1:0] tcdm_q, tcdm_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  opc_t                      opc_q, opc_d;
  logic [SID_WIDTH-1:0]      sid_q, sid_d;

  logic [BYTES_W-1:0] calc_bytes;
  logic               calc_last;
  logic               accept;

  trans_burst_calc #(
    .REM_WIDTH       (REM_W),
    .MAX_BURST_BYTES (MAX_BURST_BYTES),
    .PAGE_LOG2       (PAGE_LOG2),
    .BYTES_WIDTH     (BYTES_W)
  ) u_calc (
    .page_off_i (ext_q[PAGE_LOG2-1:0]),
    .rem_i      (rem_q),
    .bytes_o    (calc_bytes),
    .last_o     (calc_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ext_q   <= '0;
      tcdm_q  <= '0;
      rem_q   <= '0;
      opc_q   <= OPC_TX;
      sid_q   <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      tcdm_q  <= tcdm_d;
      rem_q   <= rem_d;
      opc_q   <= opc_d;
      sid_q   <= sid_d;
    end
  end

  assign accept = req_i && gnt_o;

  // Loading a new transaction takes priority over advancing the finished one.
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    tcdm_d  = tcdm_q;
    rem_d   = rem_q;
    opc_d   = opc_q;
    sid_d   = sid_q;
    if (state_q == ST_ISSUE && burst_ready_i) begin
      ext_d  = ext_q + EXT_ADD_WIDTH'(calc_bytes);
      tcdm_d = tcdm_q + TCDM_ADD_WIDTH'(calc_bytes);
      rem_d  = rem_q - REM_W'(calc_bytes);
      if (calc_last) state_d = ST_IDLE;
    end
    if (accept) begin
      ext_d   = dat_i[EXT_LSB +: EXT_ADD_WIDTH];
      tcdm_d  = dat_i[TCDM_LSB +: TCDM_ADD_WIDTH];
      rem_d   = REM_W'(dat_i[LEN_LSB +: MCHAN_LEN_WIDTH]) + REM_W'(1);
      opc_d   = opc_t'(dat_i[OPC_BIT]);
      sid_d   = dat_i[SID_LSB +: SID_WIDTH];
      state_d = ST_ISSUE;
    end
  end

  always_comb begin
    gnt_o         = 1'b0;
    burst_valid_o = 1'b0;
    burst_len_o   = '0;
    burst_last_o  = 1'b0;
    if (state_q == ST_IDLE) begin
      gnt_o = 1'b1;
    end else begin
      burst_valid_o = 1'b1;
      burst_len_o   = BURST_LEN_WIDTH'(calc_bytes - BYTES_W'(1));
      burst_last_o  = calc_last;
`ifdef TRANS_BURST_ISSUER_BACK2BACK_EN
      gnt_o         = calc_last && burst_ready_i;
`endif
    end
  end

  assign burst_ext_add_o  = ext_q;
  assign burst_tcdm_add_o = tcdm_q;
  assign burst_opc_o      = opc_q;
  assign burst_sid_o      = sid_q;
  assign busy_o           = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_trans_burst_issuer.sv
// Directed bench for trans_burst_issuer: splitting, page crossing, backpressure,
// mid-transaction reset and back-to-back spacing.
module tb_trans_burst_issuer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [84:0] dat_i = '0;
  logic        burst_valid_o;
  logic        burst_ready_i = 1'b1;
  logic [31:0] burst_ext_add_o;
  logic [31:0] burst_tcdm_add_o;
  logic [7:0]  burst_len_o;
  logic        burst_opc_o;
  logic [3:0]  burst_sid_o;
  logic        burst_last_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  wire [78:0] obs = {burst_valid_o, burst_ext_add_o, burst_tcdm_add_o, burst_len_o,
                     burst_opc_o, burst_sid_o, burst_last_o};
  logic [78:0] exp_v;

  always #5 clk_i = ~clk_i;

  trans_burst_issuer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .gnt_o            (gnt_o),
    .dat_i            (dat_i),
    .burst_valid_o    (burst_valid_o),
    .burst_ready_i    (burst_ready_i),
    .burst_ext_add_o  (burst_ext_add_o),
    .burst_tcdm_add_o (burst_tcdm_add_o),
    .burst_len_o      (burst_len_o),
    .burst_opc_o      (burst_opc_o),
    .burst_sid_o      (burst_sid_o),
    .burst_last_o     (burst_last_o),
    .busy_o           (busy_o)
  );

  function automatic logic [84:0] pack(input logic [31:0] ext, input logic [31:0] tcdm,
                                       input logic [15:0] len, input logic opc,
                                       input logic [3:0] sid);
    return {sid, opc, len, tcdm, ext};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset();
    #2;
    n_checks++;
    if (obs !== '0 || gnt_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h gnt=%b busy=%b required outputs=0 gnt=1 busy=0", obs, gnt_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (obs !== '0 || gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: outputs=%h gnt=%b required 0 / 1", obs, gnt_o);
    end
    $display("txn reset checked");
  endtask

  task automatic test_split();
    req_i = 1'b1;
    dat_i = pack(32'h1000, 32'h100, 16'h03FF, 1'b0, 4'h3);
    @(negedge clk_i);
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {1'b1, 32'h1000 + 32'(i) * 32'h100, 32'h100 + 32'(i) * 32'h100, 8'hFF, 1'b0, 4'h3, (i == 3)};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL split_burst%0d: got %h required %h", i, obs, exp_v);
      end
      @(negedge clk_i);
    end
    n_checks++;
    if (burst_valid_o !== 1'b0 || busy_o !== 1'b0 || gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL split_idle: valid=%b busy=%b gnt=%b required 0 0 1", burst_valid_o, busy_o, gnt_o);
    end
    $display("txn split ext=0x1000 len=0x3FF checked");
  endtask

  task automatic test_page_cross();
    req_i = 1'b1;
    dat_i = pack(32'h0FF0, 32'h20, 16'h001F, 1'b0, 4'h1);
    @(negedge clk_i);
    req_i = 1'b0;
    exp_v = {1'b1, 32'h0FF0, 32'h20, 8'h0F, 1'b0, 4'h1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL page_burst0: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    exp_v = {1'b1, 32'h1000, 32'h30, 8'h0F, 1'b0, 4'h1, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL page_burst1: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    $display("txn page crossing ext=0x0FF0 len=0x1F checked");
  endtask

  task automatic test_single_byte();
    req_i = 1'b1;
    dat_i = pack(32'h2000, 32'h40, 16'h0000, 1'b1, 4'h5);
    @(negedge clk_i);
    req_i = 1'b0;
    exp_v = {1'b1, 32'h2000, 32'h40, 8'h00, 1'b1, 4'h5, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL single_byte: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    n_checks++;
    if (burst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_byte_done: valid=%b required 0", burst_valid_o);
    end
    $display("txn single byte opc=1 sid=5 checked");
  endtask

  task automatic test_backpressure();
    req_i = 1'b1;
    dat_i = pack(32'h3000, 32'h0, 16'h02FF, 1'b0, 4'h7);
    @(negedge clk_i);
    req_i = 1'b0;
    exp_v = {1'b1, 32'h3000, 32'h0, 8'hFF, 1'b0, 4'h7, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_burst0: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    burst_ready_i = 1'b0;
    exp_v = {1'b1, 32'h3100, 32'h100, 8'hFF, 1'b0, 4'h7, 1'b0};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h required %h", i, obs, exp_v);
      end
      if (i < 5) @(negedge clk_i);
    end
    burst_ready_i = 1'b1;
    @(negedge clk_i);
    exp_v = {1'b1, 32'h3200, 32'h200, 8'hFF, 1'b0, 4'h7, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_burst2: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    $display("txn backpressure 5 cycles checked");
  endtask

  task automatic test_reset_mid();
    req_i = 1'b1;
    dat_i = pack(32'h4000, 32'h500, 16'h03FF, 1'b1, 4'h9);
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    exp_v = {1'b1, 32'h4100, 32'h600, 8'hFF, 1'b1, 4'h9, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid_burst1: got %h required %h", obs, exp_v);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (burst_valid_o !== 1'b0 || gnt_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: valid=%b gnt=%b busy=%b required 0 1 0", burst_valid_o, gnt_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_checks++;
      if (burst_valid_o !== 1'b0 || gnt_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_quiet%0d: valid=%b gnt=%b required 0 1", i, burst_valid_o, gnt_o);
      end
    end
    $display("txn reset during burst 2 of 4 checked");
  endtask

  task automatic test_back_to_back();
    req_i = 1'b1;
    dat_i = pack(32'h5000, 32'h10, 16'h0007, 1'b0, 4'hA);
    @(negedge clk_i);
    dat_i = pack(32'h6000, 32'h20, 16'h0003, 1'b1, 4'hB);
    exp_v = {1'b1, 32'h5000, 32'h10, 8'h07, 1'b0, 4'hA, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_first: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
`ifdef TRANS_BURST_ISSUER_BACK2BACK_EN
    req_i = 1'b0;
`else
    n_checks++;
    if (burst_valid_o !== 1'b0 || gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bubble: valid=%b gnt=%b required 0 1", burst_valid_o, gnt_o);
    end
    @(negedge clk_i);
    req_i = 1'b0;
`endif
    exp_v = {1'b1, 32'h6000, 32'h20, 8'h03, 1'b1, 4'hB, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_second: got %h required %h", obs, exp_v);
    end
    @(negedge clk_i);
    n_checks++;
    if (burst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: valid=%b required 0", burst_valid_o);
    end
    $display("txn back-to-back pair checked");
  endtask

  initial begin
    test_reset();
    test_split();
    test_page_cross();
    test_single_byte();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
